// File: rtl/run_hls_deadlock_report_ctrl.sv
// Deadlock report supervisor: qualifies sustained monitor block activity, delivers one
// report over valid/ready and keeps a sticky deadlock flag until cleared.
module run_hls_deadlock_report_ctrl #(
  parameter int NUM_MON     = 4,
  parameter int IDX_W       = 2,
  parameter int HOLD_CYCLES = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [NUM_MON-1:0] mon_block,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [IDX_W-1:0]   rpt_idx,
  output logic [NUM_MON-1:0] rpt_mask,
  output logic               deadlock,
  output logic [7:0]         rpt_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WATCH   = 2'd1,
    ST_REPORT  = 2'd2,
    ST_LATCHED = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [15:0]        run_cnt_r;
  logic [15:0]        run_cnt_nxt_s;
  logic [15:0]        run_inc_s;
  logic               any_blk_s;
  logic               qualify_s;
  logic               rpt_valid_r;
  logic [IDX_W-1:0]   rpt_idx_r;
  logic [NUM_MON-1:0] rpt_mask_r;
  logic               deadlock_r;
  logic [7:0]         rpt_count_r;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_MON-1:0] v);
    logic [IDX_W-1:0] r;
    r = {IDX_W{1'b0}};
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = IDX_W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign any_blk_s = |mon_block;
  assign run_inc_s = run_cnt_r + 16'd1;

  // Next-state, run counter and qualification strobe; clear overrides everything.
  always_comb begin
    state_nxt_s   = state_r;
    run_cnt_nxt_s = run_cnt_r;
    qualify_s     = 1'b0;
    if (clear) begin
      state_nxt_s   = ST_IDLE;
      run_cnt_nxt_s = 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enable && any_blk_s) begin
            state_nxt_s   = ST_WATCH;
            run_cnt_nxt_s = 16'd1;
          end else begin
            run_cnt_nxt_s = 16'd0;
          end
        end
        ST_WATCH: begin
          if (!enable || !any_blk_s) begin
            state_nxt_s   = ST_IDLE;
            run_cnt_nxt_s = 16'd0;
          end else if (run_inc_s == 16'(HOLD_CYCLES)) begin
            state_nxt_s   = ST_REPORT;
            run_cnt_nxt_s = run_inc_s;
            qualify_s     = 1'b1;
          end else begin
            run_cnt_nxt_s = run_inc_s;
          end
        end
        ST_REPORT: begin
          if (rpt_valid_r && rpt_ready) begin
            state_nxt_s = ST_LATCHED;
          end else begin
            state_nxt_s = ST_REPORT;
          end
        end
        ST_LATCHED: begin
          state_nxt_s = ST_LATCHED;
        end
        default: begin
          state_nxt_s   = ST_IDLE;
          run_cnt_nxt_s = 16'd0;
        end
      endcase
    end
  end

  // State, run counter and registered valid (high exactly while in REPORT).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      run_cnt_r   <= 16'd0;
      rpt_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      run_cnt_r   <= run_cnt_nxt_s;
      rpt_valid_r <= (state_nxt_s == ST_REPORT);
    end
  end

  // Report payload, sticky flag and saturating count; count survives clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rpt_idx_r   <= {IDX_W{1'b0}};
      rpt_mask_r  <= {NUM_MON{1'b0}};
      deadlock_r  <= 1'b0;
      rpt_count_r <= 8'd0;
    end else if (clear) begin
      rpt_idx_r  <= {IDX_W{1'b0}};
      rpt_mask_r <= {NUM_MON{1'b0}};
      deadlock_r <= 1'b0;
    end else if (qualify_s) begin
      rpt_idx_r  <= lowest_idx(mon_block);
      rpt_mask_r <= mon_block;
      deadlock_r <= 1'b1;
      if (rpt_count_r != 8'hFF) begin
        rpt_count_r <= rpt_count_r + 8'd1;
      end
    end
  end

  assign rpt_valid = rpt_valid_r;
  assign rpt_idx   = rpt_idx_r;
  assign rpt_mask  = rpt_mask_r;
  assign deadlock  = deadlock_r;
  assign rpt_count = rpt_count_r;

endmodule

// File: tb/tb_run_hls_deadlock_report_ctrl.sv
// Directed bench for run_hls_deadlock_report_ctrl: per-cycle comparison against an
// event-level model plus hand-computed checkpoints.
module tb_run_hls_deadlock_report_ctrl;
  localparam int H = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       clear;
  logic [3:0] mon_block;
  logic       rpt_valid;
  logic       rpt_ready;
  logic [1:0] rpt_idx;
  logic [3:0] rpt_mask;
  logic       deadlock;
  logic [7:0] rpt_count;

  int n_cmp = 0;
  int n_err = 0;

  run_hls_deadlock_report_ctrl #(.NUM_MON(4), .IDX_W(2), .HOLD_CYCLES(H)) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .mon_block(mon_block), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_idx(rpt_idx), .rpt_mask(rpt_mask), .deadlock(deadlock), .rpt_count(rpt_count)
  );

  always #5 clock = ~clock;

  // Model: run length of qualifying cycles, an outstanding report, a done flag.
  int         m_run;
  logic       m_pend, m_done, m_dead;
  logic [1:0] m_idx;
  logic [3:0] m_mask;
  int         m_cnt;

  function automatic logic [1:0] first_set(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_run <= 0; m_pend <= 1'b0; m_done <= 1'b0; m_dead <= 1'b0;
      m_idx <= 2'd0; m_mask <= 4'd0; m_cnt <= 0;
    end else if (clear) begin
      m_run <= 0; m_pend <= 1'b0; m_done <= 1'b0; m_dead <= 1'b0;
      m_idx <= 2'd0; m_mask <= 4'd0;
    end else if (m_pend) begin
      if (rpt_ready) begin
        m_pend <= 1'b0;
        m_done <= 1'b1;
      end
    end else if (!m_done) begin
      if (enable && (mon_block != 4'd0)) begin
        if (m_run + 1 == H) begin
          m_pend <= 1'b1; m_dead <= 1'b1; m_mask <= mon_block;
          m_idx <= first_set(mon_block);
          m_cnt <= (m_cnt >= 255) ? 255 : m_cnt + 1;
          m_run <= 0;
        end else begin
          m_run <= m_run + 1;
        end
      end else begin
        m_run <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      chk("valid", 32'(rpt_valid), 32'(m_pend));
      chk("idx", 32'(rpt_idx), 32'(m_idx));
      chk("mask", 32'(rpt_mask), 32'(m_mask));
      chk("deadlock", 32'(deadlock), 32'(m_dead));
      chk("count", 32'(rpt_count), 32'(m_cnt));
    end
  end

  task automatic step(input logic en, input logic [3:0] mon, input logic rdy, input logic clr);
    enable = en; mon_block = mon; rpt_ready = rdy; clear = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic steps(input int n, input logic en, input logic [3:0] mon,
                       input logic rdy, input logic clr);
    for (int k = 0; k < n; k++) step(en, mon, rdy, clr);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; clear = 1'b0; mon_block = 4'd0; rpt_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    chk("rst_valid", 32'(rpt_valid), 32'd0);
    chk("rst_deadlock", 32'(deadlock), 32'd0);
    chk("rst_count", 32'(rpt_count), 32'd0);
    chk("rst_mask", 32'(rpt_mask), 32'd0);

    // Glitch rejection: one zero cycle restarts the run.
    steps(15, 1'b1, 4'b0001, 1'b1, 1'b0);
    step(1'b1, 4'b0000, 1'b1, 1'b0);
    steps(15, 1'b1, 4'b0001, 1'b1, 1'b0);
    step(1'b1, 4'b0000, 1'b1, 1'b0);
    chk("glitch_valid", 32'(rpt_valid), 32'd0);
    chk("glitch_deadlock", 32'(deadlock), 32'd0);
    chk("glitch_count", 32'(rpt_count), 32'd0);

    // Qualify: valid appears exactly after HOLD_CYCLES edges, for one cycle.
    steps(15, 1'b1, 4'b0110, 1'b1, 1'b0);
    chk("q_early_valid", 32'(rpt_valid), 32'd0);
    step(1'b1, 4'b0110, 1'b1, 1'b0);
    chk("q_valid", 32'(rpt_valid), 32'd1);
    chk("q_idx", 32'(rpt_idx), 32'd1);
    chk("q_mask", 32'(rpt_mask), 32'h6);
    chk("q_deadlock", 32'(deadlock), 32'd1);
    chk("q_count", 32'(rpt_count), 32'd1);
    step(1'b1, 4'b0000, 1'b1, 1'b0);
    chk("q_valid_drop", 32'(rpt_valid), 32'd0);
    chk("q_sticky", 32'(deadlock), 32'd1);
    step(1'b0, 4'b0000, 1'b0, 1'b1);
    chk("q_clr_deadlock", 32'(deadlock), 32'd0);
    chk("q_clr_count", 32'(rpt_count), 32'd1);

    // Backpressure: payload holds while ready is low; no second report in LATCHED.
    steps(16, 1'b1, 4'b1000, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", 32'(rpt_valid), 32'd1);
      chk("bp_idx", 32'(rpt_idx), 32'd3);
      chk("bp_mask", 32'(rpt_mask), 32'h8);
      step(k[0], 4'(k), 1'b0, 1'b0);
    end
    step(1'b1, 4'b0001, 1'b1, 1'b0);
    chk("bp_done", 32'(rpt_valid), 32'd0);
    steps(40, 1'b1, 4'b1111, 1'b1, 1'b0);
    chk("bp_latched_valid", 32'(rpt_valid), 32'd0);
    chk("bp_latched_count", 32'(rpt_count), 32'd2);
    chk("bp_latched_idx", 32'(rpt_idx), 32'd3);
    step(1'b0, 4'b0000, 1'b0, 1'b1);

    // Clear beats a handshake in the same cycle; re-arm restarts from 1.
    steps(16, 1'b1, 4'b0010, 1'b0, 1'b0);
    chk("cp_valid", 32'(rpt_valid), 32'd1);
    step(1'b1, 4'b0010, 1'b1, 1'b1);
    chk("cp_valid_after", 32'(rpt_valid), 32'd0);
    chk("cp_deadlock", 32'(deadlock), 32'd0);
    chk("cp_mask", 32'(rpt_mask), 32'd0);
    chk("cp_count", 32'(rpt_count), 32'd3);
    steps(15, 1'b1, 4'b0010, 1'b0, 1'b0);
    chk("rearm_early", 32'(rpt_valid), 32'd0);
    step(1'b1, 4'b0010, 1'b0, 1'b0);
    chk("rearm_valid", 32'(rpt_valid), 32'd1);
    chk("rearm_count", 32'(rpt_count), 32'd4);
    step(1'b0, 4'b0000, 1'b0, 1'b1);

    // Clear on the qualifying edge suppresses the report.
    steps(15, 1'b1, 4'b0100, 1'b0, 1'b0);
    step(1'b1, 4'b0100, 1'b0, 1'b1);
    chk("cq_valid", 32'(rpt_valid), 32'd0);
    chk("cq_count", 32'(rpt_count), 32'd4);
    step(1'b1, 4'b0000, 1'b0, 1'b0);

    // Enable drop at run_cnt=10 returns to IDLE without a report.
    steps(10, 1'b1, 4'b0001, 1'b1, 1'b0);
    step(1'b0, 4'b0001, 1'b1, 1'b0);
    steps(10, 1'b1, 4'b0001, 1'b1, 1'b0);
    step(1'b1, 4'b0000, 1'b1, 1'b0);
    chk("en_valid", 32'(rpt_valid), 32'd0);
    chk("en_count", 32'(rpt_count), 32'd4);

    // Asynchronous reset in REPORT clears outputs before the next edge.
    steps(16, 1'b1, 4'b1100, 1'b0, 1'b0);
    chk("ar_valid_pre", 32'(rpt_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", 32'(rpt_valid), 32'd0);
    chk("ar_deadlock", 32'(deadlock), 32'd0);
    chk("ar_mask", 32'(rpt_mask), 32'd0);
    chk("ar_count", 32'(rpt_count), 32'd0);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    reset = 1'b1;

    // Saturation: dropped-by-clear reports still count, capped at 255.
    for (int r = 0; r < 260; r++) begin
      steps(16, 1'b1, 4'b0001, 1'b0, 1'b0);
      step(1'b0, 4'b0000, 1'b0, 1'b1);
    end
    chk("sat_count", 32'(rpt_count), 32'd255);
    steps(16, 1'b1, 4'b0001, 1'b1, 1'b0);
    chk("sat_valid", 32'(rpt_valid), 32'd1);
    chk("sat_hold", 32'(rpt_count), 32'd255);
    step(1'b0, 4'b0000, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/run_hls_deadlock_report_ctrl.md
# run_hls_deadlock_report_ctrl

Supervisory controller for the per-instance HLS deadlock monitors. It collects the `block` outputs of up to NUM_MON monitors and qualifies them: a report is raised only when some monitor has asserted block continuously for HOLD_CYCLES cycles. It then delivers one report over a valid/ready handshake to the debug/status path and holds a sticky deadlock flag until software clears it.

## Interface
- NUM_MON, default 4: number of monitor `block` inputs; legal range 1–16.
- IDX_W, default 2: width of the reported index; must satisfy 2^IDX_W >= NUM_MON.
- HOLD_CYCLES, default 16: consecutive blocked cycles required before a report; legal range 2–65535.

- clock  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  arms qualification; low forces IDLE from WATCH.
- clear  in  1  synchronous single-cycle clear; returns the block to IDLE from any state.
- mon_block  in  NUM_MON  block outputs of the deadlock monitors, one bit per monitor.
- rpt_valid  out  1  report available.
- rpt_ready  in  1  consumer accepts the report.
- rpt_idx  out  IDX_W  lowest-numbered blocked monitor at qualification.
- rpt_mask  out  NUM_MON  snapshot of mon_block at qualification.
- deadlock  out  1  sticky flag; set on qualification, cleared by clear or reset.
- rpt_count  out  8  reports issued since reset; saturates at 255.

## Operation
- States: IDLE, WATCH, REPORT, LATCHED.
- Run counter `run_cnt` is 16 bits wide and counts consecutive cycles with |mon_block=1.
- IDLE:
  - If enable=1 and |mon_block=1, go to WATCH with run_cnt=1.
  - Otherwise run_cnt=0.
- WATCH:
  - If mon_block=0 or enable=0, go to IDLE with run_cnt=0.
  - Otherwise increment run_cnt. When the incremented value equals HOLD_CYCLES, go to REPORT.
  - In the same edge, capture rpt_mask=mon_block and rpt_idx=index of the lowest set bit, set deadlock=1, and increment rpt_count (saturating).
- REPORT:
  - rpt_valid=1. rpt_idx and rpt_mask are held stable until the handshake.
  - On rpt_valid & rpt_ready, go to LATCHED.
  - mon_block and enable are ignored in this state.
- LATCHED:
  - rpt_valid=0. deadlock, rpt_idx and rpt_mask are held.
  - Stays here until clear. Never produces a second report without clear.
- clear=1:
  - In any state, next state is IDLE with run_cnt=0 and deadlock=0.
  - rpt_idx and rpt_mask are zeroed. rpt_count is not affected.
  - clear has priority over every other transition, including a handshake or qualification in the same cycle.
  - A report dropped by clear is still counted.
- Reset values: state IDLE, rpt_valid=0, rpt_idx=0, rpt_mask=0, deadlock=0, rpt_count=0, run_cnt=0.
- Reset mid-REPORT drops the report immediately (asynchronous) with no handshake.
- Changes in mon_block during WATCH that keep it nonzero (for example, a different monitor taking over) do not restart run_cnt.

## Timing
- Inputs are sampled directly with no input register.
- Qualification latency: if mon_block is nonzero in cycles t .. t+HOLD_CYCLES-1 (enable=1, starting from IDLE), then rpt_valid and deadlock are high in cycle t+HOLD_CYCLES.
- A single zero cycle at or before t+HOLD_CYCLES-1 prevents the report.
- Handshake: data is transferred on the rising edge where rpt_valid=rpt_ready=1; rpt_valid is low the next cycle.
  - rpt_ready may be high before rpt_valid; transfer then occurs in the first REPORT cycle.
  - rpt_valid never drops without a transfer, except on clear or reset.
- The earliest re-arm after clear is the cycle after clear; the run count restarts from 1.
- All outputs are registered.

## Test plan
- Qualify, default parameters: mon_block=4'b0110 for 16 cycles from t, rpt_ready=1 → rpt_valid high exactly at t+16 for one cycle, rpt_idx=1, rpt_mask=4'b0110, deadlock=1, rpt_count=1.
- Glitch rejection: mon_block=4'b0001 for 15 cycles, 0 for 1 cycle, then 4'b0001 for 15 cycles → no rpt_valid, deadlock=0, rpt_count=0.
- Backpressure: qualify with rpt_ready=0 for 10 cycles → rpt_valid, rpt_idx and rpt_mask stable for all 10 cycles; after rpt_ready=1, one transfer and state LATCHED; later mon_block activity produces no report.
- Clear priority: in REPORT, assert clear and rpt_ready in the same cycle → state IDLE, rpt_valid=0, deadlock=0, rpt_mask=0, rpt_count unchanged at 1.
- Enable and reset: drop enable at run_cnt=10 → IDLE and no report. Assert reset low mid-REPORT → all outputs zero asynchronously, before the next clock edge.
- Saturation: 260 qualify/clear cycles → rpt_count reads 255 and stays there.
